// File: rtl/regfile_2w2r_if.sv
// Register-file port bundle: two read ports, two write ports, clear handshake.
// Master = datapath side (decode/writeback), slave = register file.
interface regfile_2w2r_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] RA;
  logic [ADDR_WIDTH-1:0] RB;
  logic [DATA_WIDTH-1:0] BusA;
  logic [DATA_WIDTH-1:0] BusB;
  logic                  RegWr0;
  logic [ADDR_WIDTH-1:0] RW0;
  logic [DATA_WIDTH-1:0] BusW0;
  logic                  RegWr1;
  logic [ADDR_WIDTH-1:0] RW1;
  logic [DATA_WIDTH-1:0] BusW1;
  logic                  ClrReq;
  logic                  Busy;
  logic                  WrErr;

  modport master (
    output RA, RB,
    output RegWr0, RW0, BusW0,
    output RegWr1, RW1, BusW1,
    output ClrReq,
    input  BusA, BusB, Busy, WrErr
  );

  modport slave (
    input  RA, RB,
    input  RegWr0, RW0, BusW0,
    input  RegWr1, RW1, BusW1,
    input  ClrReq,
    output BusA, BusB, Busy, WrErr
  );
endinterface

// File: rtl/regfile_2w2r.sv
// 2-write / 2-read register file with hardwired zero register and bulk clear.
// Define REGFILE_BYPASS_EN to forward same-cycle writes onto the read ports.
module regfile_2w2r #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 31
) (
  input  logic          Clk,
  input  logic          Rst_n,
  regfile_2w2r_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [ADDR_WIDTH-1:0] ZeroAddr =
    ADDR_WIDTH'(ZERO_REG);
  localparam logic [ADDR_WIDTH-1:0] LastAddr = '1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } fsmState_t;

  fsmState_t state;
  fsmState_t stateNext;

  logic                  busy;
  logic                  clrEn;
  logic [ADDR_WIDTH-1:0] ptr;

  logic                  wrEn0;
  logic                  wrEn1;
  logic                  dropWr;
  logic                  wrErr;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DATA_WIDTH-1:0] busANext;
  logic [DATA_WIDTH-1:0] busBNext;
  logic [DATA_WIDTH-1:0] busAQ;
  logic [DATA_WIDTH-1:0] busBQ;

  // FSM: state register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // FSM: next state
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: begin
        if (bus.ClrReq) begin
          stateNext = CLEAR;
        end
      end
      CLEAR: begin
        if (ptr == LastAddr) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy  = 1'b0;
    clrEn = 1'b0;
    unique case (state)
      IDLE: begin
        busy  = 1'b0;
        clrEn = 1'b0;
      end
      CLEAR: begin
        busy  = 1'b1;
        clrEn = 1'b1;
      end
      default: begin
        busy  = 1'b0;
        clrEn = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ptr <= '0;
    end else if (state == IDLE && bus.ClrReq) begin
      ptr <= '0;
    end else if (clrEn) begin
      ptr <= ptr + 1'b1;
    end
  end

  // Zero-register writes are neither stored nor reported as errors.
  always_comb begin
    wrEn0  = bus.RegWr0 && !busy && (bus.RW0 != ZeroAddr);
    wrEn1  = bus.RegWr1 && !busy && (bus.RW1 != ZeroAddr);
    dropWr = busy &&
      ((bus.RegWr0 && (bus.RW0 != ZeroAddr)) ||
       (bus.RegWr1 && (bus.RW1 != ZeroAddr)));
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wrErr <= 1'b0;
    end else begin
      wrErr <= dropWr;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : gReg
    localparam logic [ADDR_WIDTH-1:0] Idx =
      ADDR_WIDTH'(g);
    if (g == ZERO_REG) begin : gZero
      assign regs[g] = '0;
    end else begin : gData
      logic [DATA_WIDTH-1:0] q;
      always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
          q <= '0;
        end else if (clrEn && ptr == Idx) begin
          q <= '0;
        end else if (wrEn1 && bus.RW1 == Idx) begin
          q <= bus.BusW1;
        end else if (wrEn0 && bus.RW0 == Idx) begin
          q <= bus.BusW0;
        end
      end
      assign regs[g] = q;
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Port 1 beats port 0, matching the write priority.
  always_comb begin
    busANext = regs[bus.RA];
    if (bus.RA == ZeroAddr) begin
      busANext = '0;
    end else if (wrEn1 && bus.RW1 == bus.RA) begin
      busANext = bus.BusW1;
    end else if (wrEn0 && bus.RW0 == bus.RA) begin
      busANext = bus.BusW0;
    end
  end

  always_comb begin
    busBNext = regs[bus.RB];
    if (bus.RB == ZeroAddr) begin
      busBNext = '0;
    end else if (wrEn1 && bus.RW1 == bus.RB) begin
      busBNext = bus.BusW1;
    end else if (wrEn0 && bus.RW0 == bus.RB) begin
      busBNext = bus.BusW0;
    end
  end
`else
  always_comb begin
    busANext = regs[bus.RA];
    busBNext = regs[bus.RB];
    if (bus.RA == ZeroAddr) begin
      busANext = '0;
    end
    if (bus.RB == ZeroAddr) begin
      busBNext = '0;
    end
  end
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      busAQ <= '0;
      busBQ <= '0;
    end else begin
      busAQ <= busANext;
      busBQ <= busBNext;
    end
  end

  assign bus.BusA  = busAQ;
  assign bus.BusB  = busBQ;
  assign bus.Busy  = busy;
  assign bus.WrErr = wrErr;

endmodule
